// File: rtl/keypad_pkg.sv
// Shared scan codes, FSM state type and the scan-code decoder for keypad_entry.
package keypad_pkg;

    // Index i holds the make code for digit i.
    localparam logic [9:0][7:0] SC_MAIN = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                           8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
    localparam logic [9:0][7:0] SC_KPAD = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                           8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};
    localparam logic [7:0] SC_ACCEPT = 8'h1C;
    localparam logic [7:0] SC_BKSP   = 8'h14;
    localparam logic [7:0] SC_ESC    = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic       is_digit;
        logic       is_accept;
        logic       is_bksp;
        logic       is_esc;
        logic [3:0] digit;
    } key_t;

    function automatic key_t decode_key(input logic [7:0] code);
        key_t k;
        k = '0;
        for (int i = 0; i < 10; i++) begin
            if (code == SC_MAIN[i] || code == SC_KPAD[i]) begin
                k.is_digit = 1'b1;
                k.digit    = 4'(i);
            end
        end
        k.is_accept = (code == SC_ACCEPT);
        k.is_bksp   = (code == SC_BKSP);
        k.is_esc    = (code == SC_ESC);
        return k;
    endfunction

endpackage

// File: rtl/keypad_key_sync.sv
// One key channel: 2-flop synchroniser plus edge flop on key_on, 2-flop code
// chain, and a one-deep event latch holding the code captured at the rising edge.
module keypad_key_sync (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       i_key_on,
    input  logic [7:0] i_key_code,
    input  logic       i_take,
    output logic       o_pending,
    output logic [7:0] o_code
);

    logic [2:0] r_on_sync;
    logic [7:0] r_code_s1;
    logic [7:0] r_code_s2;
    logic       r_pending;
    logic [7:0] r_code;
    logic       w_rise;

    assign w_rise = r_on_sync[1] & ~r_on_sync[2];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_on_sync <= '0;
            r_code_s1 <= '0;
            r_code_s2 <= '0;
            r_pending <= 1'b0;
            r_code    <= '0;
        end else begin
            r_on_sync <= {r_on_sync[1:0], i_key_on};
            r_code_s1 <= i_key_code;
            r_code_s2 <= r_code_s1;
            // A fresh edge wins over the arbiter draining the latch.
            if (w_rise) begin
                r_pending <= 1'b1;
                r_code    <= r_code_s2;
            end else if (i_take) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_code    = r_code;

endmodule

// File: rtl/keypad_entry.sv
// Two-channel keypad front end to fixed-length BCD entry with valid/ack handshake.
// Optional inactivity timeout in ENTRY is built only when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                key1_on,
    input  logic [7:0]          key1_code,
    input  logic                key2_on,
    input  logic [7:0]          key2_code,
    input  logic                entry_ack,
    output logic [4*DIGITS-1:0] entry_bcd,
    output logic [3:0]          digit_cnt,
    output logic                entry_valid,
    output logic                entry_cancel,
    output logic                key_err
);

    localparam int BCD_W = 4 * DIGITS;

    logic             w_pend1, w_pend2;
    logic [7:0]       w_code1, w_code2;
    logic             w_take1, w_take2;
    logic             w_event;
    key_t             w_key;
    logic             w_timeout;

    state_t           r_state, w_state_nx;
    logic [BCD_W-1:0] r_bcd, w_bcd_nx;
    logic [3:0]       r_cnt, w_cnt_nx;
    logic             r_cancel, w_cancel_nx;
    logic             r_err, w_err_nx;

    keypad_key_sync u_sync1 (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .i_key_on   (key1_on),
        .i_key_code (key1_code),
        .i_take     (w_take1),
        .o_pending  (w_pend1),
        .o_code     (w_code1)
    );

    keypad_key_sync u_sync2 (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .i_key_on   (key2_on),
        .i_key_code (key2_code),
        .i_take     (w_take2),
        .o_pending  (w_pend2),
        .o_code     (w_code2)
    );

    // Key1 has fixed priority; events in DONE are still drained, just discarded.
    assign w_take1 = w_pend1;
    assign w_take2 = w_pend2 & ~w_pend1;
    assign w_event = w_pend1 | w_pend2;
    assign w_key   = decode_key(w_pend1 ? w_code1 : w_code2);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] r_idle_cnt;

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
        end else if (r_state != ST_ENTRY || w_event || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_ENTRY) && !w_event &&
                       (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nx  = r_state;
        w_bcd_nx    = r_bcd;
        w_cnt_nx    = r_cnt;
        w_cancel_nx = 1'b0;
        w_err_nx    = 1'b0;
        case (r_state)
            ST_IDLE, ST_ENTRY: begin
                if (w_event) begin
                    if (w_key.is_digit) begin
                        if (r_cnt < 4'(DIGITS)) begin
                            w_bcd_nx   = (r_bcd << 4) | BCD_W'(w_key.digit);
                            w_cnt_nx   = r_cnt + 4'd1;
                            w_state_nx = ST_ENTRY;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end else if (w_key.is_bksp) begin
                        if (r_state == ST_ENTRY) begin
                            w_bcd_nx = r_bcd >> 4;
                            w_cnt_nx = r_cnt - 4'd1;
                            if (r_cnt == 4'd1) w_state_nx = ST_IDLE;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end else if (w_key.is_accept) begin
                        if (r_state == ST_ENTRY && r_cnt == 4'(DIGITS)) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_err_nx = 1'b1;
                        end
                    end else if (w_key.is_esc) begin
                        w_bcd_nx    = '0;
                        w_cnt_nx    = '0;
                        w_cancel_nx = 1'b1;
                        w_state_nx  = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_bcd_nx    = '0;
                    w_cnt_nx    = '0;
                    w_cancel_nx = 1'b1;
                    w_state_nx  = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (entry_ack) begin
                    w_bcd_nx   = '0;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_cancel <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_bcd    <= w_bcd_nx;
            r_cnt    <= w_cnt_nx;
            r_cancel <= w_cancel_nx;
            r_err    <= w_err_nx;
        end
    end

    assign entry_bcd    = r_bcd;
    assign digit_cnt    = r_cnt;
    assign entry_valid  = (r_state == ST_DONE);
    assign entry_cancel = r_cancel;
    assign key_err      = r_err;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry (DIGITS=4, TIMEOUT_CYCLES=100);
// the timeout step runs only when KEYPAD_TIMEOUT_EN is defined.
module tb_keypad_entry;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        key1_on = 1'b0;
    logic [7:0]  key1_code = 8'h00;
    logic        key2_on = 1'b0;
    logic [7:0]  key2_code = 8'h00;
    logic        entry_ack = 1'b0;
    logic [15:0] entry_bcd;
    logic [3:0]  digit_cnt;
    logic        entry_valid;
    logic        entry_cancel;
    logic        key_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_err_pulses = 0;
    int n_cancel_pulses = 0;
    int err_base;
    int cancel_base;

    keypad_entry #(.DIGITS(4), .TIMEOUT_CYCLES(100)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .key1_on      (key1_on),
        .key1_code    (key1_code),
        .key2_on      (key2_on),
        .key2_code    (key2_code),
        .entry_ack    (entry_ack),
        .entry_bcd    (entry_bcd),
        .digit_cnt    (digit_cnt),
        .entry_valid  (entry_valid),
        .entry_cancel (entry_cancel),
        .key_err      (key_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (key_err)      n_err_pulses++;
        if (entry_cancel) n_cancel_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic press(input bit ch, input logic [7:0] code);
        @(negedge sys_clk);
        if (ch) begin key2_code = code; key2_on = 1'b1; end
        else    begin key1_code = code; key1_on = 1'b1; end
        repeat (6) @(negedge sys_clk);
        key1_on = 1'b0;
        key2_on = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_bcd", 32'(entry_bcd), 32'h0);
        chk("rst_cnt", 32'(digit_cnt), 32'h0);
        chk("rst_valid", 32'(entry_valid), 32'h0);
        chk("rst_cancel", 32'(entry_cancel), 32'h0);
        chk("rst_err", 32'(key_err), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Latency: update lands on the 4th rising edge after key1_on rises
        key1_code = 8'h16;
        key1_on   = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("lat_edge3_cnt", 32'(digit_cnt), 32'h0);
        @(negedge sys_clk);
        chk("lat_edge4_cnt", 32'(digit_cnt), 32'h1);
        chk("lat_edge4_bcd", 32'(entry_bcd), 32'h1);
        repeat (3) @(negedge sys_clk);
        key1_on = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("held_one_event", 32'(digit_cnt), 32'h1);

        press(0, 8'h1E);
        press(0, 8'h26);
        press(0, 8'h25);
        chk("four_bcd", 32'(entry_bcd), 32'h1234);
        chk("four_cnt", 32'(digit_cnt), 32'h4);

        // Fifth digit rejected
        err_base = n_err_pulses;
        press(0, 8'h16);
        chk("fifth_err", 32'(n_err_pulses - err_base), 32'h1);
        chk("fifth_bcd", 32'(entry_bcd), 32'h1234);

        // Accept, then keys in DONE are discarded
        press(0, 8'h1C);
        chk("done_valid", 32'(entry_valid), 32'h1);
        chk("done_bcd", 32'(entry_bcd), 32'h1234);
        err_base    = n_err_pulses;
        cancel_base = n_cancel_pulses;
        press(0, 8'h16);
        press(1, 8'h76);
        press(0, 8'h14);
        chk("done_keys_bcd", 32'(entry_bcd), 32'h1234);
        chk("done_keys_valid", 32'(entry_valid), 32'h1);
        chk("done_keys_err", 32'(n_err_pulses - err_base), 32'h0);
        chk("done_keys_cancel", 32'(n_cancel_pulses - cancel_base), 32'h0);

        // Ack clears on the next cycle
        @(negedge sys_clk);
        entry_ack = 1'b1;
        @(negedge sys_clk);
        entry_ack = 1'b0;
        chk("ack_valid", 32'(entry_valid), 32'h0);
        chk("ack_bcd", 32'(entry_bcd), 32'h0);
        chk("ack_cnt", 32'(digit_cnt), 32'h0);

        // Backspace in IDLE rejected
        err_base = n_err_pulses;
        press(0, 8'h14);
        chk("idle_bksp_err", 32'(n_err_pulses - err_base), 32'h1);
        chk("idle_bksp_cnt", 32'(digit_cnt), 32'h0);

        // Keypad digits with backspace
        press(0, 8'h69);
        press(1, 8'h72);
        press(0, 8'h14);
        press(0, 8'h7D);
        chk("kp_bcd", 32'(entry_bcd), 32'h0019);
        chk("kp_cnt", 32'(digit_cnt), 32'h2);

        // Accept with three digits rejected
        press(0, 8'h75);
        err_base = n_err_pulses;
        press(0, 8'h1C);
        chk("short_acc_err", 32'(n_err_pulses - err_base), 32'h1);
        chk("short_acc_valid", 32'(entry_valid), 32'h0);
        chk("short_acc_bcd", 32'(entry_bcd), 32'h0198);

        // Unknown code ignored silently, then Esc clears
        err_base = n_err_pulses;
        press(0, 8'h1A);
        chk("unknown_err", 32'(n_err_pulses - err_base), 32'h0);
        chk("unknown_bcd", 32'(entry_bcd), 32'h0198);
        cancel_base = n_cancel_pulses;
        press(0, 8'h76);
        chk("esc_cancel", 32'(n_cancel_pulses - cancel_base), 32'h1);
        chk("esc_bcd", 32'(entry_bcd), 32'h0);
        chk("esc_cnt", 32'(digit_cnt), 32'h0);

        // Simultaneous edges served on consecutive cycles, key1 first
        key1_code = 8'h16;
        key2_code = 8'h1E;
        key1_on   = 1'b1;
        key2_on   = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("coll_edge4_bcd", 32'(entry_bcd), 32'h0001);
        @(negedge sys_clk);
        chk("coll_edge5_bcd", 32'(entry_bcd), 32'h0012);
        chk("coll_edge5_cnt", 32'(digit_cnt), 32'h2);
        key1_on = 1'b0;
        key2_on = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Key2 alone, then backspace down to IDLE
        press(1, 8'h3D);
        chk("k2_bcd", 32'(entry_bcd), 32'h0127);
        press(0, 8'h14);
        press(1, 8'h14);
        press(0, 8'h14);
        chk("bksp_empty_cnt", 32'(digit_cnt), 32'h0);
        err_base = n_err_pulses;
        press(0, 8'h14);
        chk("bksp_empty_idle", 32'(n_err_pulses - err_base), 32'h1);

        // Asynchronous reset mid-entry
        press(0, 8'h46);
        press(0, 8'h3E);
        @(negedge sys_clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_bcd", 32'(entry_bcd), 32'h0);
        chk("arst_cnt", 32'(digit_cnt), 32'h0);
        chk("arst_valid", 32'(entry_valid), 32'h0);

        // Key held through reset release yields one event
        key1_code = 8'h26;
        key1_on   = 1'b1;
        @(negedge sys_clk);
        reset = 1'b1;
        repeat (8) @(negedge sys_clk);
        key1_on = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("held_rst_bcd", 32'(entry_bcd), 32'h0003);
        chk("held_rst_cnt", 32'(digit_cnt), 32'h1);

`ifdef KEYPAD_TIMEOUT_EN
        press(0, 8'h76);
        repeat (2) @(negedge sys_clk);
        cancel_base = n_cancel_pulses;
        key1_code = 8'h3E;
        key1_on   = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("to_start_cnt", 32'(digit_cnt), 32'h1);
        repeat (3) @(negedge sys_clk);
        key1_on = 1'b0;
        repeat (96) @(negedge sys_clk);
        chk("to_before_cnt", 32'(digit_cnt), 32'h1);
        chk("to_before_cancel", 32'(n_cancel_pulses - cancel_base), 32'h0);
        @(negedge sys_clk);
        chk("to_pulse", 32'(entry_cancel), 32'h1);
        chk("to_cnt", 32'(digit_cnt), 32'h0);
        chk("to_bcd", 32'(entry_bcd), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Converts the PS/2 keyboard front end's two-key outputs (`key1_on/key1_code`, `key2_on/key2_code`) into a fixed-length BCD entry for the parking controller. It runs in the `sys_clk` domain and synchronises each key channel. It detects key presses, decodes digit and command scan codes, and edits a DIGITS-long buffer. A completed entry is presented with a valid/ack handshake.

## Interface
Parameters:
- `DIGITS`, 4: entry length in BCD digits (1–8).
- `TIMEOUT_CYCLES`, 50_000_000: inactivity limit in `sys_clk` cycles. Used only when `KEYPAD_TIMEOUT_EN` is defined.

Ports (reset reset, asynchronous, active-low; clock sys_clk):
- `sys_clk`  in  1  system clock.
- `reset`  in  1  asynchronous active-low reset.
- `key1_on`, `key2_on`  in  1 each  key-held levels from the keyboard stage (asynchronous to `sys_clk`).
- `key1_code`, `key2_code`  in  8 each  make codes; each is stable while its `_on` is high.
- `entry_ack`  in  1  consumer has taken the entry.
- `entry_bcd`  out  4*DIGITS  buffer. Most recent digit is in [3:0]; unused digits are 0.
- `digit_cnt`  out  4  number of digits entered.
- `entry_valid`  out  1  level; the entry is complete and waiting for ack.
- `entry_cancel`  out  1  one-cycle pulse on Esc or timeout.
- `key_err`  out  1  one-cycle pulse when a key is rejected.

## Operation
- Per channel: 2-flop synchroniser on `_on`, plus a 3rd flop for edge detection. `_code` runs through a parallel 2-flop chain. A rising edge sets that channel's one-deep event latch, holding the stage-2 code.
- Arbiter: serves at most one event per cycle, key1 latch before key2. Simultaneous edges are therefore served in consecutive cycles. A new edge on a channel whose latch is still full overwrites it.
- Digit codes:
  - Main row: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
  - Keypad: 0x70=0, 0x69=1, 0x72=2, 0x7A=3, 0x6B=4, 0x73=5, 0x74=6, 0x6C=7, 0x75=8, 0x7D=9.
- Command codes: 0x1C = accept, 0x14 = backspace, 0x76 = Esc. Any other code is ignored silently, with no `key_err`.
- States:
  - IDLE: `digit_cnt` = 0.
  - ENTRY: 1..DIGITS digits held.
  - DONE: `entry_valid` = 1.
- Digit, in IDLE or ENTRY:
  - If `digit_cnt` < DIGITS: shift `entry_bcd` left 4, insert the digit, increment `digit_cnt`, go to ENTRY.
  - Otherwise: pulse `key_err`, buffer unchanged.
- Backspace:
  - In ENTRY: shift right 4, decrement `digit_cnt`; go to IDLE if the count reaches 0.
  - In IDLE: pulse `key_err`.
- Accept:
  - In ENTRY with `digit_cnt` == DIGITS: go to DONE.
  - Otherwise, in IDLE or ENTRY: pulse `key_err`.
- Esc, in IDLE or ENTRY: clear buffer and count, pulse `entry_cancel`, go to IDLE.
- DONE: every key event is discarded, with no `key_err`. `entry_ack` = 1 clears buffer and count and goes to IDLE. `entry_ack` outside DONE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, synchronisers and latches 0. A key held through reset release produces one event.
- Latency: `keyN_on` rising edge → outputs updated on the 4th `sys_clk` edge, or 5th for key2 when it collides with key1.
- `entry_valid` rises on the cycle after the accept event is served. It falls on the cycle after `entry_ack` is sampled high.
- `entry_cancel` and `key_err` are single-cycle pulses registered with the state update.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - A counter runs in ENTRY and is zeroed on every served key event, including rejected ones.
  - When it reaches TIMEOUT_CYCLES−1: clear buffer, pulse `entry_cancel`, go to IDLE.
  - The counter is held at 0 in IDLE and DONE. DONE never times out.
- Not defined: no counter is built, and ENTRY persists indefinitely.

## Structure
- `keypad_pkg` holds:
  - scan-code localparams;
  - the state enum (IDLE/ENTRY/DONE);
  - a `decode_key` function returning {is_digit, is_accept, is_bksp, is_esc, digit[3:0]}.
- Sub-module `keypad_key_sync`: synchroniser, edge detector and event latch for one channel. Instantiated twice.

## Test plan
- Key1 presses "1","2","3","4" (0x16, 0x1E, 0x26, 0x25), then "A" (0x1C) → `entry_bcd` = 0x1234, `digit_cnt` = 4, `entry_valid` = 1. Pulse `entry_ack` → all zero, IDLE.
- Keypad 0x69, 0x72, then backspace 0x14, then 0x7D → `entry_bcd` = 0x0019, `digit_cnt` = 2.
- Fifth digit after four, accept with 3 digits, backspace in IDLE → one `key_err` pulse each, buffer unchanged.
- `key1_on` and `key2_on` rise in the same cycle with 0x16 and 0x1E → `entry_bcd` = 0x0012, events served in consecutive cycles.
- Esc (0x76) with 2 digits → `entry_cancel` pulse, cleared. Keys in DONE → ignored, `entry_bcd` unchanged.
- With `KEYPAD_TIMEOUT_EN` and TIMEOUT_CYCLES = 100: one digit, then idle → cancel pulse after 100 cycles. Assert `reset` mid-entry → all outputs 0 immediately.
